// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, receiver FSM states and the
// sample-tick divisor used by the RX (and future TX) baud generators.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } uart_state_t;

  // Clocks per sample tick, rounded to nearest.
  function automatic int f_baud_div(input int clk, input int baud, input int os);
    return (clk + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: one-cycle o_tick every DIV clocks while i_clr is low.
// i_clr holds the count at zero, so the first tick lands DIV clocks after release.
module uart_baud_tick #(
  parameter int DIV = 326
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = w_wrap && !i_clr;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with 3-sample majority vote, false-start rejection,
// parity/framing/break flags; o_rcv_flag ~3 clocks after the last stop-bit decision point.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rcv_flag,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int DIV = f_baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);

  localparam logic [OSW-1:0] OS_S0   = OSW'(OVERSAMPLE / 2 - 2);
  localparam logic [OSW-1:0] OS_S1   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_DEC  = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_t          r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [OSW-1:0]       r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic                 r_v0;
  logic                 r_v1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_par_err;
  logic                 r_ferr_acc;
  logic                 r_stop0;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rcv_flag;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_break;
  logic                 r_busy;

  logic w_tick;
  logic w_idle;
  logic w_start_edge;
  logic w_vote;
  logic w_dec;
  logic w_bit_end;
  logic w_par_calc;
  logic w_par_err;
  logic w_stop0;
  logic w_brk;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_idle       = (r_state == ST_IDLE);
  assign w_start_edge = w_idle && r_rx_prev && !r_rx_s;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_rst_n),
    .i_clr   (w_idle),
    .o_tick  (w_tick)
  );

  // Sample-tick position within the current bit plus the first two votes.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_os_cnt <= '0;
      r_v0     <= 1'b1;
      r_v1     <= 1'b1;
    end else if (w_idle) begin
      r_os_cnt <= '0;
    end else if (w_tick) begin
      r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
      if (r_os_cnt == OS_S0) r_v0 <= r_rx_s;
      if (r_os_cnt == OS_S1) r_v1 <= r_rx_s;
    end
  end

  assign w_dec      = w_tick && (r_os_cnt == OS_DEC);
  assign w_bit_end  = w_tick && (r_os_cnt == OS_LAST);
  assign w_vote     = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);
  assign w_par_calc = (^r_shift) ^ w_vote;
  assign w_par_err  = (PARITY == PAR_ODD) ? !w_par_calc : w_par_calc;
  assign w_stop0    = (r_bit_cnt == 4'd0) ? w_vote : r_stop0;
  assign w_brk      = (r_shift == '0) && ((PARITY == PAR_NONE) || !r_par_bit) && !w_stop0;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_par_err    <= 1'b0;
      r_ferr_acc   <= 1'b0;
      r_stop0      <= 1'b1;
      r_data       <= '0;
      r_rcv_flag   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_break      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rcv_flag <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_state    <= ST_START;
            r_busy     <= 1'b1;
            r_par_bit  <= 1'b0;
            r_par_err  <= 1'b0;
            r_ferr_acc <= 1'b0;
          end
        end
        ST_START: begin
          if (w_dec && w_vote) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_dec) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_bit_end) begin
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_dec) begin
            r_par_bit <= w_vote;
            r_par_err <= w_par_err;
          end
          if (w_bit_end) begin
            r_state   <= ST_STOP;
            r_bit_cnt <= '0;
          end
        end
        ST_STOP: begin
          // Frame completes mid last stop bit so a following start edge is not missed.
          if (w_dec) begin
            if (r_bit_cnt == 4'd0) r_stop0 <= w_vote;
            if (!w_vote) r_ferr_acc <= 1'b1;
            if (r_bit_cnt == STOP_LAST) begin
              r_rcv_flag   <= 1'b1;
              r_data       <= r_shift;
              r_frame_err  <= r_ferr_acc | ~w_vote;
              r_parity_err <= (PARITY != PAR_NONE) && r_par_err;
              r_break      <= w_brk;
              r_state      <= w_brk ? ST_BRK_WAIT : ST_IDLE;
              r_busy       <= w_brk;
            end
          end else if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_BRK_WAIT: begin
          if (r_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_rcv_flag   = r_rcv_flag;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_break      = r_break;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench: an 8N1 receiver (a) and an 8E1 receiver (b), 64 clocks per bit.
module tb_uart_rx_cfg;

  localparam int CLK_HZ  = 614_400;
  localparam int BAUD    = 9600;
  localparam int BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] data_a, data_b;
  logic       flag_a, flag_b;
  logic       fe_a, fe_b;
  logic       pe_a, pe_b;
  logic       brk_a, brk_b;
  logic       busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int flags_a = 0;
  int flags_b = 0;
  int exp_a   = 0;
  int exp_b   = 0;
  int flag_cyc_a = 0;
  int start_cyc  = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) u_dut_a (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx(rx_a),
    .o_data(data_a), .o_rcv_flag(flag_a), .o_frame_err(fe_a),
    .o_parity_err(pe_a), .o_break(brk_a), .o_busy(busy_a)
  );

  uart_rx_cfg #(
    .CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)
  ) u_dut_b (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_rx(rx_b),
    .o_data(data_b), .o_rcv_flag(flag_b), .o_frame_err(fe_b),
    .o_parity_err(pe_b), .o_break(brk_b), .o_busy(busy_b)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (flag_a) begin
      flags_a++;
      flag_cyc_a = cyc;
    end
    if (flag_b) flags_b++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_bit(input int ln, input logic v);
    if (ln == 0) rx_a = v;
    else         rx_b = v;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input int ln, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop_v);
    start_cyc = cyc;
    drive_bit(ln, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(ln, d[i]);
    if (has_par) drive_bit(ln, pbit);
    drive_bit(ln, stop_v);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs_a", 32'({data_a, flag_a, fe_a, pe_a, brk_a, busy_a}), 0);
    check("reset_outputs_b", 32'({data_b, flag_b, fe_b, pe_b, brk_b, busy_b}), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Clean 8N1 frame, with latency to the flag.
    send_frame(0, 8'h6A, 0, 1'b0, 1'b1);
    exp_a++;
    check("6a_flags", flags_a, exp_a);
    check("6a_data", 32'(data_a), 'h6A);
    check("6a_errs", 32'({fe_a, pe_a, brk_a}), 0);
    check("6a_busy_low", 32'(busy_a), 0);
    check("6a_latency", flag_cyc_a - start_cyc, 615);

    // Even parity: 5A has four ones, so parity bit 1 is wrong and 0 is right.
    send_frame(1, 8'h5A, 1, 1'b1, 1'b1);
    exp_b++;
    check("par_bad_flags", flags_b, exp_b);
    check("par_bad_data", 32'(data_b), 'h5A);
    check("par_bad_pe", 32'(pe_b), 1);
    check("par_bad_fe", 32'(fe_b), 0);
    send_frame(1, 8'h5A, 1, 1'b0, 1'b1);
    exp_b++;
    check("par_ok_flags", flags_b, exp_b);
    check("par_ok_pe", 32'(pe_b), 0);

    // Stop bit low, then a clean frame clears the framing error.
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    exp_a++;
    check("ferr_flags", flags_a, exp_a);
    check("ferr_fe", 32'(fe_a), 1);
    check("ferr_brk", 32'(brk_a), 0);
    check("ferr_data", 32'(data_a), 'h3C);
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    exp_a++;
    check("a5_flags", flags_a, exp_a);
    check("a5_data", 32'(data_a), 'hA5);
    check("a5_fe", 32'(fe_a), 0);

    // Three-tick low glitch is rejected as a false start.
    rx_a = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_busy_high", 32'(busy_a), 1);
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    check("glitch_busy_low", 32'(busy_a), 0);
    check("glitch_flags", flags_a, exp_a);
    check("glitch_data", 32'(data_a), 'hA5);

    // Twenty bit times of break: one flag, held until the line rises.
    rx_a = 1'b0;
    repeat (20 * BIT_CYC) @(negedge clk);
    check("brk_busy_held", 32'(busy_a), 1);
    rx_a = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    exp_a++;
    check("brk_flags", flags_a, exp_a);
    check("brk_brk", 32'(brk_a), 1);
    check("brk_fe", 32'(fe_a), 1);
    check("brk_data", 32'(data_a), 0);
    check("brk_busy_low", 32'(busy_a), 0);
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    exp_a++;
    check("81_flags", flags_a, exp_a);
    check("81_data", 32'(data_a), 'h81);
    check("81_errs", 32'({fe_a, pe_a, brk_a}), 0);

    // Back-to-back frames, then reset in the middle of a third.
    send_frame(0, 8'h00, 0, 1'b0, 1'b1);
    exp_a++;
    check("b2b0_flags", flags_a, exp_a);
    check("b2b0_data", 32'(data_a), 'h00);
    send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
    exp_a++;
    check("b2b1_flags", flags_a, exp_a);
    check("b2b1_data", 32'(data_a), 'hFF);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 32'({data_a, flag_a, fe_a, pe_a, brk_a, busy_a}), 0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    check("rst_after_flags", flags_a, exp_a);
    check("rst_after_outputs", 32'({data_a, flag_a, fe_a, pe_a, brk_a, busy_a}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
